// File: rtl/prefix_counter.sv
// Up/down counter with programmable modulus, wrap/saturate bound handling and
// a parallel-prefix incrementer/decrementer selectable between serial, Brent-Kung and Sklansky.
module prefix_counter #(
  parameter int unsigned width = 8,
  parameter int unsigned speed = 2,
  parameter int unsigned sat   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic [width-1:0] MAX,
  input  logic             CLR,
  output logic [width-1:0] Q,
  output logic             TC,
  output logic             OVF,
  output logic             ZERO
);

  localparam int unsigned N = width + 1;
  localparam int unsigned L = $clog2(N);

  // Prefix AND: p[i] = x[0] & x[1] & ... & x[i], built in place level by level.
  function automatic logic [N-1:0] prefix_and(input logic [N-1:0] x);
    logic [N-1:0] p;
    p = x;
    if (speed == 0) begin
      for (int i = 1; i < int'(N); i++) p[i] = p[i] & p[i-1];
    end else if (speed == 1) begin
      for (int l = 0; l < int'(L); l++) begin
        for (int i = 0; i < int'(N); i++) begin
          if (((i + 1) % (1 << (l + 1))) == 0) p[i] = p[i] & p[i - (1 << l)];
        end
      end
      for (int l = int'(L) - 1; l >= 0; l--) begin
        for (int i = 0; i < int'(N); i++) begin
          if (((i + 1) % (1 << (l + 1))) == (1 << l) && i >= (1 << (l + 1)))
            p[i] = p[i] & p[i - (1 << l)];
        end
      end
    end else begin
      for (int l = 0; l < int'(L); l++) begin
        for (int i = 0; i < int'(N); i++) begin
          if (((i >> l) & 1) == 1) p[i] = p[i] & p[((i >> l) << l) - 1];
        end
      end
    end
    return p;
  endfunction

  logic [width-1:0] r_q, w_q_d;
  logic             r_tc, w_tc_d;
  logic             r_ovf, w_ovf_d;
  logic [N-1:0]     w_pinc, w_pdec;
  logic [width-1:0] w_inc, w_dec;
  logic             w_q_zero, w_at_max, w_set_ovf;
  logic             w_unused_all_ones;

  assign w_pinc = prefix_and({r_q, 1'b1});
  assign w_pdec = prefix_and({~r_q, 1'b1});
  assign w_inc  = r_q ^ w_pinc[width-1:0];
  assign w_dec  = r_q ^ w_pdec[width-1:0];
  // Top prefix bit of the decrement chain is exactly "all bits of Q are zero".
  assign w_q_zero          = w_pdec[width];
  assign w_unused_all_ones = w_pinc[width];
  assign w_at_max          = (r_q >= MAX);

  always_comb begin
    w_q_d     = r_q;
    w_tc_d    = 1'b0;
    w_set_ovf = 1'b0;
    if (LD) begin
      w_q_d = D;
    end else if (EN) begin
      if (UP) begin
        if (w_at_max) begin
          w_tc_d    = 1'b1;
          w_q_d     = (sat != 0) ? MAX : '0;
          w_set_ovf = (sat != 0);
        end else begin
          w_q_d = w_inc;
        end
      end else begin
        if (w_q_zero) begin
          w_tc_d    = 1'b1;
          w_q_d     = (sat != 0) ? '0 : MAX;
          w_set_ovf = (sat != 0);
        end else begin
          w_q_d = w_dec;
        end
      end
    end
    // Set beats clear when both happen on the same edge.
    w_ovf_d = w_set_ovf | (r_ovf & ~CLR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_d;
      r_tc  <= w_tc_d;
      r_ovf <= w_ovf_d;
    end
  end

  assign Q    = r_q;
  assign TC   = r_tc;
  assign OVF  = r_ovf;
  assign ZERO = w_q_zero;

endmodule

// File: tb/tb_prefix_counter.sv
// Directed and model-checked random stimulus for prefix_counter across widths,
// bound modes and all three prefix structures.
module tb_prefix_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, ld, clr;
  logic [3:0] d4, max4;
  logic [4:0] d5, max5;

  logic [3:0] q4a, q4b;
  logic       tc4a, ovf4a, zero4a, tc4b, ovf4b, zero4b;
  logic [4:0] q5 [4];
  logic       tc5 [4];
  logic       ovf5 [4];
  logic       zero5 [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prefix_counter #(.width(4), .speed(2), .sat(0)) u_w4_wrap (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d4), .MAX(max4), .CLR(clr),
    .Q(q4a), .TC(tc4a), .OVF(ovf4a), .ZERO(zero4a)
  );
  prefix_counter #(.width(4), .speed(0), .sat(1)) u_w4_sat (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d4), .MAX(max4), .CLR(clr),
    .Q(q4b), .TC(tc4b), .OVF(ovf4b), .ZERO(zero4b)
  );
  prefix_counter #(.width(5), .speed(0), .sat(0)) u_w5_s0 (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d5), .MAX(max5), .CLR(clr),
    .Q(q5[0]), .TC(tc5[0]), .OVF(ovf5[0]), .ZERO(zero5[0])
  );
  prefix_counter #(.width(5), .speed(1), .sat(0)) u_w5_s1 (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d5), .MAX(max5), .CLR(clr),
    .Q(q5[1]), .TC(tc5[1]), .OVF(ovf5[1]), .ZERO(zero5[1])
  );
  prefix_counter #(.width(5), .speed(2), .sat(0)) u_w5_s2 (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d5), .MAX(max5), .CLR(clr),
    .Q(q5[2]), .TC(tc5[2]), .OVF(ovf5[2]), .ZERO(zero5[2])
  );
  prefix_counter #(.width(5), .speed(1), .sat(1)) u_w5_sat (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d5), .MAX(max5), .CLR(clr),
    .Q(q5[3]), .TC(tc5[3]), .OVF(ovf5[3]), .ZERO(zero5[3])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld  = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (q4a !== 4'd0 || tc4a !== 1'b0 || ovf4a !== 1'b0 || zero4a !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_wrap: Q=%0d TC=%b OVF=%b ZERO=%b, required Q=0 TC=0 OVF=0 ZERO=1",
               q4a, tc4a, ovf4a, zero4a);
    end
    n_cmp++;
    if (q4b !== 4'd0 || tc4b !== 1'b0 || ovf4b !== 1'b0 || zero4b !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_sat: Q=%0d TC=%b OVF=%b ZERO=%b, required Q=0 TC=0 OVF=0 ZERO=1",
               q4b, tc4b, ovf4b, zero4b);
    end
    // Count a few steps, then reset together with load and enable.
    max4 = 4'hF; up = 1'b1; en = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; ld = 1'b1; d4 = 4'd7;
    tick();
    n_cmp++;
    if (q4a !== 4'd0 || tc4a !== 1'b0 || ovf4a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_over_load: Q=%0d TC=%b OVF=%b, required Q=0 TC=0 OVF=0",
               q4a, tc4a, ovf4a);
    end
    rst = 1'b0; ld = 1'b0; en = 1'b0;
  endtask

  task automatic test_wrap_up();
    apply_reset();
    max4 = 4'hF; up = 1'b1; en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (q4a !== 4'(k % 16) || tc4a !== (k == 16) || ovf4a !== 1'b0 || zero4a !== (k == 16))
      begin
        n_bad++;
        $display("FAIL wrap_up step %0d: Q=%0d TC=%b OVF=%b ZERO=%b, required Q=%0d TC=%b OVF=0",
                 k, q4a, tc4a, ovf4a, zero4a, k % 16, (k == 16));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'd9; exp_q[1] = 4'd8; exp_q[2] = 4'd7;
    apply_reset();
    max4 = 4'd9; ld = 1'b1; d4 = 4'd0;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (q4a !== exp_q[k] || tc4a !== (k == 0)) begin
        n_bad++;
        $display("FAIL down_wrap step %0d: Q=%0d TC=%b, required Q=%0d TC=%b",
                 k, q4a, tc4a, exp_q[k], (k == 0));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_above_max();
    apply_reset();
    max4 = 4'd9; d4 = 4'd12; ld = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    n_cmp++;
    if (q4a !== 4'd12 || tc4a !== 1'b0) begin
      n_bad++;
      $display("FAIL load_with_en: Q=%0d TC=%b, required Q=12 TC=0", q4a, tc4a);
    end
    ld = 1'b0;
    tick();
    n_cmp++;
    if (q4a !== 4'd0 || tc4a !== 1'b1) begin
      n_bad++;
      $display("FAIL above_max_up: Q=%0d TC=%b, required Q=0 TC=1", q4a, tc4a);
    end
    ld = 1'b1;
    tick();
    ld = 1'b0; up = 1'b0;
    tick();
    n_cmp++;
    if (q4a !== 4'd11 || tc4a !== 1'b0) begin
      n_bad++;
      $display("FAIL above_max_down: Q=%0d TC=%b, required Q=11 TC=0", q4a, tc4a);
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    max4 = 4'd5; up = 1'b1; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (q4b !== 4'((k <= 5) ? k : 5) || tc4b !== (k >= 6) || ovf4b !== (k >= 6)) begin
        n_bad++;
        $display("FAIL sat_up step %0d: Q=%0d TC=%b OVF=%b, required Q=%0d TC=%b OVF=%b",
                 k, q4b, tc4b, ovf4b, (k <= 5) ? k : 5, (k >= 6), (k >= 6));
      end
    end
    en = 1'b0; clr = 1'b1;
    tick();
    n_cmp++;
    if (q4b !== 4'd5 || tc4b !== 1'b0 || ovf4b !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_clr: Q=%0d TC=%b OVF=%b, required Q=5 TC=0 OVF=0", q4b, tc4b, ovf4b);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (q4b !== 4'd5 || tc4b !== 1'b1 || ovf4b !== 1'b1) begin
      n_bad++;
      $display("FAIL set_beats_clr: Q=%0d TC=%b OVF=%b, required Q=5 TC=1 OVF=1",
               q4b, tc4b, ovf4b);
    end
    clr = 1'b0; ld = 1'b1; d4 = 4'd2;
    tick();
    n_cmp++;
    if (q4b !== 4'd2 || tc4b !== 1'b0 || ovf4b !== 1'b1) begin
      n_bad++;
      $display("FAIL load_keeps_ovf: Q=%0d TC=%b OVF=%b, required Q=2 TC=0 OVF=1",
               q4b, tc4b, ovf4b);
    end
    ld = 1'b0; up = 1'b0;
    tick(); tick();
    n_cmp++;
    if (q4b !== 4'd0 || tc4b !== 1'b0 || zero4b !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_down_to_zero: Q=%0d TC=%b ZERO=%b, required Q=0 TC=0 ZERO=1",
               q4b, tc4b, zero4b);
    end
    tick();
    n_cmp++;
    if (q4b !== 4'd0 || tc4b !== 1'b1 || ovf4b !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_down_floor: Q=%0d TC=%b OVF=%b, required Q=0 TC=1 OVF=1",
               q4b, tc4b, ovf4b);
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if (q4b !== 4'd0 || tc4b !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_no_tc: Q=%0d TC=%b, required Q=0 TC=0", q4b, tc4b);
    end
  endtask

  task automatic test_max_zero();
    apply_reset();
    max4 = 4'd0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up = k[0];
      tick();
      n_cmp++;
      if (q4a !== 4'd0 || tc4a !== 1'b1 || ovf4a !== 1'b0 ||
          q4b !== 4'd0 || tc4b !== 1'b1 || ovf4b !== 1'b1) begin
        n_bad++;
        $display("FAIL max_zero step %0d: wrap Q=%0d TC=%b OVF=%b sat Q=%0d TC=%b OVF=%b, %s",
                 k, q4a, tc4a, ovf4a, q4b, tc4b, ovf4b,
                 "required wrap Q=0 TC=1 OVF=0 sat Q=0 TC=1 OVF=1");
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] m_q [2];
    logic       m_tc [2];
    logic       m_ovf [2];
    logic       set;
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      m_q[s] = '0; m_tc[s] = 1'b0; m_ovf[s] = 1'b0;
    end
    max5 = 5'd31;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(63) == 0);
      ld  = ($urandom_range(15) == 0);
      en  = ($urandom_range(3) != 0);
      up  = ($urandom_range(1) == 1);
      clr = ($urandom_range(7) == 0);
      d5  = 5'($urandom_range(31));
      case ($urandom_range(15))
        0: max5 = 5'($urandom_range(31));
        1: max5 = 5'd31;
        2: max5 = 5'd0;
        3: max5 = 5'($urandom_range(6));
        default: ;
      endcase
      for (int s = 0; s < 2; s++) begin
        set = 1'b0;
        if (rst) begin
          m_q[s] = '0; m_tc[s] = 1'b0; m_ovf[s] = 1'b0;
        end else begin
          m_tc[s] = 1'b0;
          if (ld) begin
            m_q[s] = d5;
          end else if (en && up) begin
            if (m_q[s] >= max5) begin
              m_tc[s] = 1'b1; set = (s == 1);
              m_q[s] = (s == 1) ? max5 : 5'd0;
            end else m_q[s] = m_q[s] + 5'd1;
          end else if (en) begin
            if (m_q[s] == 5'd0) begin
              m_tc[s] = 1'b1; set = (s == 1);
              m_q[s] = (s == 1) ? 5'd0 : max5;
            end else m_q[s] = m_q[s] - 5'd1;
          end
          m_ovf[s] = set | (m_ovf[s] & ~clr);
        end
      end
      tick();
      for (int u = 0; u < 4; u++) begin
        automatic int s = (u == 3) ? 1 : 0;
        n_cmp++;
        if (q5[u] !== m_q[s] || tc5[u] !== m_tc[s] || ovf5[u] !== m_ovf[s] ||
            zero5[u] !== (m_q[s] == 5'd0)) begin
          n_bad++;
          $display("FAIL random cyc %0d dut %0d: Q=%0d TC=%b OVF=%b ZERO=%b, required Q=%0d TC=%b OVF=%b",
                   c, u, q5[u], tc5[u], ovf5[u], zero5[u], m_q[s], m_tc[s], m_ovf[s]);
        end
      end
    end
    rst = 1'b0; ld = 1'b0; en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; clr = 1'b0;
    d4 = '0; max4 = 4'hF; d5 = '0; max5 = 5'd31;
    test_reset();
    test_wrap_up();
    test_down_wrap();
    test_load_above_max();
    test_saturate();
    test_max_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
